// File: rtl/rgb_sequencer.sv
// Steps the RGB PWM duty values through a programmable colour table, holding each
// entry for a programmable number of ticks from an external prescaler.
module rgb_sequencer #(
  parameter int  NUM_ENTRIES     = 8,
  parameter int  COLOR_WIDTH     = 8,
  parameter int  DURATION_WIDTH  = 16,
  parameter int  PRESCALER_WIDTH = 8,
  localparam int IDX_W           = $clog2(NUM_ENTRIES)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [IDX_W-1:0]           wr_addr,
  input  logic [COLOR_WIDTH-1:0]     wr_red,
  input  logic [COLOR_WIDTH-1:0]     wr_green,
  input  logic [COLOR_WIDTH-1:0]     wr_blue,
  input  logic [DURATION_WIDTH-1:0]  wr_duration,
  input  logic [PRESCALER_WIDTH-1:0] cfg_limit,
  input  logic [IDX_W-1:0]           cfg_last,
  input  logic                       cfg_loop,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       tick,
  output logic [PRESCALER_WIDTH-1:0] presc_limit,
  output logic                       presc_reset,
  output logic [COLOR_WIDTH-1:0]     red,
  output logic [COLOR_WIDTH-1:0]     green,
  output logic [COLOR_WIDTH-1:0]     blue,
  output logic [IDX_W-1:0]           index,
  output logic                       busy,
  output logic                       done
);

  typedef struct packed {
    logic [COLOR_WIDTH-1:0]    red;
    logic [COLOR_WIDTH-1:0]    green;
    logic [COLOR_WIDTH-1:0]    blue;
    logic [DURATION_WIDTH-1:0] duration;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HOLD
  } state_t;

  entry_t table_q [NUM_ENTRIES];
  entry_t table_d [NUM_ENTRIES];
  entry_t wr_entry;
  entry_t cur_entry;

  state_t                       state_q, state_d;
  logic [IDX_W-1:0]             index_q, index_d;
  logic [IDX_W-1:0]             last_q, last_d;
  logic                         loop_q, loop_d;
  logic [PRESCALER_WIDTH-1:0]   limit_q, limit_d;
  logic [DURATION_WIDTH-1:0]    remaining_q, remaining_d;
  logic [COLOR_WIDTH-1:0]       red_q, red_d;
  logic [COLOR_WIDTH-1:0]       green_q, green_d;
  logic [COLOR_WIDTH-1:0]       blue_q, blue_d;
  logic                         done_q, done_d;

  assign wr_entry  = {wr_red, wr_green, wr_blue, wr_duration};
  // Table is flop-based so a LOAD in the write cycle naturally sees the old entry.
  assign cur_entry = table_q[index_q];

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      table_d[i] = table_q[i];
      if (wr_en && (wr_addr == IDX_W'(i))) begin
        table_d[i] = wr_entry;
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (reset) begin
        table_q[i] <= '0;
      end else begin
        table_q[i] <= table_d[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    last_d      = last_q;
    loop_d      = loop_q;
    limit_d     = limit_q;
    remaining_d = remaining_q;
    red_d       = red_q;
    green_d     = green_q;
    blue_d      = blue_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d = ST_LOAD;
          index_d = '0;
          last_d  = cfg_last;
          loop_d  = cfg_loop;
          limit_d = (cfg_limit == '0) ? PRESCALER_WIDTH'(1) : cfg_limit;
        end
      end

      ST_LOAD: begin
        if (stop) begin
          state_d = ST_IDLE;
          index_d = '0;
          red_d   = '0;
          green_d = '0;
          blue_d  = '0;
        end else begin
          state_d     = ST_HOLD;
          red_d       = cur_entry.red;
          green_d     = cur_entry.green;
          blue_d      = cur_entry.blue;
          remaining_d = (cur_entry.duration == '0) ? DURATION_WIDTH'(1) : cur_entry.duration;
        end
      end

      ST_HOLD: begin
        if (stop) begin
          state_d = ST_IDLE;
          index_d = '0;
          red_d   = '0;
          green_d = '0;
          blue_d  = '0;
        end else if (tick) begin
          if (remaining_q > DURATION_WIDTH'(1)) begin
            remaining_d = remaining_q - 1'b1;
          end else if (index_q != last_q) begin
            index_d = index_q + 1'b1;
            state_d = ST_LOAD;
          end else if (loop_q) begin
            index_d = '0;
            state_d = ST_LOAD;
          end else begin
            // Natural end of a one-shot sequence; index is left on the last step.
            state_d = ST_IDLE;
            red_d   = '0;
            green_d = '0;
            blue_d  = '0;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      index_q     <= '0;
      last_q      <= '0;
      loop_q      <= 1'b0;
      limit_q     <= '0;
      remaining_q <= '0;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      last_q      <= last_d;
      loop_q      <= loop_d;
      limit_q     <= limit_d;
      remaining_q <= remaining_d;
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
      done_q      <= done_d;
    end
  end

  // The prescaler is held in reset everywhere but HOLD, so its count is 0 on HOLD entry.
  assign presc_reset = (state_q != ST_HOLD);
  assign presc_limit = limit_q;
  assign busy        = (state_q != ST_IDLE);
  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign index       = index_q;
  assign done        = done_q;

endmodule

// File: tb/tb_rgb_sequencer.sv
// Scoreboard bench for rgb_sequencer: expected steps are queued at start and
// compared as each step (LOAD + HOLD) completes; an external prescaler is modelled here.
module tb_rgb_sequencer;

  localparam int NE = 8;
  localparam int CW = 8;
  localparam int DW = 16;
  localparam int PW = 8;
  localparam int IW = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [IW-1:0] wr_addr = '0;
  logic [CW-1:0] wr_red = '0, wr_green = '0, wr_blue = '0;
  logic [DW-1:0] wr_duration = '0;
  logic [PW-1:0] cfg_limit = '0;
  logic [IW-1:0] cfg_last = '0;
  logic          cfg_loop = 1'b0;
  logic          start = 1'b0, stop = 1'b0;
  logic          tick;
  logic [PW-1:0] presc_limit;
  logic          presc_reset;
  logic [CW-1:0] red, green, blue;
  logic [IW-1:0] index;
  logic          busy, done;

  rgb_sequencer #(
    .NUM_ENTRIES(NE), .COLOR_WIDTH(CW), .DURATION_WIDTH(DW), .PRESCALER_WIDTH(PW)
  ) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_red(wr_red), .wr_green(wr_green), .wr_blue(wr_blue), .wr_duration(wr_duration),
    .cfg_limit(cfg_limit), .cfg_last(cfg_last), .cfg_loop(cfg_loop),
    .start(start), .stop(stop), .tick(tick),
    .presc_limit(presc_limit), .presc_reset(presc_reset),
    .red(red), .green(green), .blue(blue), .index(index), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // External prescaler: counts 0..limit-1 and pulses tick on the last count.
  logic [PW-1:0] presc_cnt;
  always @(posedge clock) begin
    if (presc_reset) presc_cnt <= '0;
    else if (presc_cnt == presc_limit - 8'd1) presc_cnt <= '0;
    else presc_cnt <= presc_cnt + 8'd1;
  end
  assign tick = !presc_reset && (presc_cnt == presc_limit - 8'd1);

  typedef struct {
    int idx;
    int rgb;
    int cycles;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   done_count = 0;
  bit   abort_pending = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic push_step(input int idx, input int r, input int g, input int b,
                           input int dur, input int lim);
    exp_t e;
    e.idx    = idx;
    e.rgb    = (r << 16) | (g << 8) | b;
    e.cycles = ((dur == 0) ? 1 : dur) * ((lim == 0) ? 1 : lim) + 1;
    sb_q.push_back(e);
  endtask

  // Monitor: a step runs from its LOAD cycle until the next LOAD or busy falling.
  bit          step_open = 1'b0;
  bit          first_hold = 1'b0;
  bit          stable = 1'b1;
  int          step_cycles = 0;
  logic [IW-1:0] obs_idx = '0;
  logic [23:0] obs_rgb = '0;

  task automatic close_step();
    exp_t e;
    check_eq("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq("step_idx", 32'(obs_idx), e.idx);
      check_eq("step_rgb", 32'(obs_rgb), e.rgb);
      check_eq("step_cycles", step_cycles, e.cycles);
      check_eq("step_stable", 32'(stable), 32'd1);
    end
    step_open = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (busy && presc_reset) begin
        if (step_open) close_step();
        step_open   = 1'b1;
        step_cycles = 1;
        first_hold  = 1'b1;
        obs_idx     = index;
      end else if (busy) begin
        step_cycles++;
        if (first_hold) begin
          obs_rgb    = {red, green, blue};
          first_hold = 1'b0;
          stable     = 1'b1;
        end else if ({red, green, blue} != obs_rgb) begin
          stable = 1'b0;
        end
      end else if (step_open) begin
        if (abort_pending) begin
          step_open     = 1'b0;
          abort_pending = 1'b0;
        end else begin
          close_step();
        end
      end
      if (done) begin
        done_count++;
        check_eq("done_busy", 32'(busy), 32'd0);
        check_eq("done_rgb", 32'({red, green, blue}), 32'd0);
      end
    end
  end

  task automatic write_entry(input int a, input int r, input int g, input int b, input int d);
    wr_addr     = IW'(a);
    wr_red      = CW'(r);
    wr_green    = CW'(g);
    wr_blue     = CW'(b);
    wr_duration = DW'(d);
    wr_en       = 1'b1;
    @(negedge clock);
    wr_en       = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_cond(input int idx, input bit want_load, input bit need_tick, input string tag);
    bit found = 1'b0;
    for (int n = 0; n < 400 && !found; n++) begin
      @(negedge clock);
      if (busy && index == IW'(idx) && presc_reset == want_load && (!need_tick || tick))
        found = 1'b1;
    end
    check_eq(tag, 32'(found), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    bit found = 1'b0;
    for (int n = 0; n < 400 && !found; n++) begin
      @(negedge clock);
      if (!busy) found = 1'b1;
    end
    check_eq(tag, 32'(found), 32'd1);
    repeat (2) @(negedge clock);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_presc_reset"}, 32'(presc_reset), 32'd1);
    check_eq({tag, "_rgb"}, 32'({red, green, blue}), 32'd0);
    check_eq({tag, "_index"}, 32'(index), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clock);
    check_idle_outputs("rst");
    check_eq("rst_presc_limit", 32'(presc_limit), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // One-shot run of three colours, L=4
    write_entry(0, 8'hFF, 8'h00, 8'h00, 2);
    write_entry(1, 8'h00, 8'hFF, 8'h00, 1);
    write_entry(2, 8'h00, 8'h00, 8'hFF, 3);
    cfg_limit = 8'd4; cfg_last = 3'd2; cfg_loop = 1'b0;
    push_step(0, 8'hFF, 8'h00, 8'h00, 2, 4);
    push_step(1, 8'h00, 8'hFF, 8'h00, 1, 4);
    push_step(2, 8'h00, 8'h00, 8'hFF, 3, 4);
    done_count = 0;
    pulse_start();
    check_eq("lat_load_busy", 32'(busy), 32'd1);
    check_eq("lat_load_rgb", 32'({red, green, blue}), 32'd0);
    @(negedge clock);
    check_eq("lat_hold_rgb", 32'({red, green, blue}), 32'hFF0000);
    check_eq("presc_limit_4", 32'(presc_limit), 32'd4);
    // cfg changes and a second start while busy must not disturb the run
    cfg_limit = 8'd9; cfg_last = 3'd0; cfg_loop = 1'b1;
    pulse_start();
    wait_idle("t1_idle");
    check_eq("t1_done_count", done_count, 1);
    check_eq("t1_sb_empty", 32'(sb_q.size()), 32'd0);

    // Looping two-step run, stop coinciding with a tick in HOLD
    cfg_limit = 8'd4; cfg_last = 3'd1; cfg_loop = 1'b1;
    push_step(0, 8'hFF, 8'h00, 8'h00, 2, 4);
    push_step(1, 8'h00, 8'hFF, 8'h00, 1, 4);
    push_step(0, 8'hFF, 8'h00, 8'h00, 2, 4);
    push_step(1, 8'h00, 8'hFF, 8'h00, 1, 4);
    done_count = 0;
    pulse_start();
    wait_cond(1, 1'b0, 1'b0, "t2_w1");
    wait_cond(0, 1'b0, 1'b0, "t2_w2");
    wait_cond(1, 1'b0, 1'b0, "t2_w3");
    wait_cond(0, 1'b0, 1'b1, "t2_w4");
    abort_pending = 1'b1;
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    check_idle_outputs("t2_stop");
    repeat (2) @(negedge clock);
    check_eq("t2_done_count", done_count, 0);
    check_eq("t2_sb_empty", 32'(sb_q.size()), 32'd0);

    // Zero duration and zero limit are both clamped to 1
    write_entry(0, 8'h11, 8'h22, 8'h33, 0);
    cfg_limit = 8'd0; cfg_last = 3'd0; cfg_loop = 1'b0;
    push_step(0, 8'h11, 8'h22, 8'h33, 0, 0);
    done_count = 0;
    pulse_start();
    check_eq("t3_presc_limit", 32'(presc_limit), 32'd1);
    wait_idle("t3_idle");
    check_eq("t3_done_count", done_count, 1);
    check_eq("t3_sb_empty", 32'(sb_q.size()), 32'd0);

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1;
    @(negedge clock);
    start = 1'b0; stop = 1'b0;
    check_eq("ss_busy", 32'(busy), 32'd0);
    check_eq("ss_presc_reset", 32'(presc_reset), 32'd1);
    @(negedge clock);
    check_eq("ss_busy2", 32'(busy), 32'd0);

    // Reset during HOLD of entry 1, then restart from a cleared table
    cfg_limit = 8'd2; cfg_last = 3'd2; cfg_loop = 1'b0;
    push_step(0, 8'h11, 8'h22, 8'h33, 0, 2);
    pulse_start();
    wait_cond(1, 1'b0, 1'b0, "t5_w1");
    abort_pending = 1'b1;
    reset = 1'b1;
    @(negedge clock);
    check_idle_outputs("t5_rst");
    check_eq("t5_presc_limit", 32'(presc_limit), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    cfg_limit = 8'd1; cfg_last = 3'd0; cfg_loop = 1'b0;
    push_step(0, 0, 0, 0, 0, 1);
    done_count = 0;
    pulse_start();
    wait_idle("t5_idle");
    check_eq("t5_done_count", done_count, 1);
    check_eq("t5_sb_empty", 32'(sb_q.size()), 32'd0);

    // Rewrites of the displayed entry and of an entry in its own LOAD cycle
    write_entry(0, 8'h10, 8'h20, 8'h30, 1);
    write_entry(1, 8'h40, 8'h50, 8'h60, 2);
    write_entry(2, 8'h70, 8'h80, 8'h90, 1);
    cfg_limit = 8'd2; cfg_last = 3'd2; cfg_loop = 1'b1;
    push_step(0, 8'h10, 8'h20, 8'h30, 1, 2);
    push_step(1, 8'h40, 8'h50, 8'h60, 2, 2);
    push_step(2, 8'h70, 8'h80, 8'h90, 1, 2);
    push_step(0, 8'h10, 8'h20, 8'h30, 1, 2);
    push_step(1, 8'hAA, 8'hBB, 8'hCC, 2, 2);
    push_step(2, 8'hDD, 8'hEE, 8'hFF, 1, 2);
    done_count = 0;
    pulse_start();
    wait_cond(1, 1'b0, 1'b0, "t6_w1");
    write_entry(1, 8'hAA, 8'hBB, 8'hCC, 2);
    wait_cond(2, 1'b1, 1'b0, "t6_w2");
    write_entry(2, 8'hDD, 8'hEE, 8'hFF, 1);
    wait_cond(1, 1'b0, 1'b0, "t6_w3");
    wait_cond(0, 1'b0, 1'b1, "t6_w4");
    abort_pending = 1'b1;
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    check_idle_outputs("t6_stop");
    repeat (2) @(negedge clock);
    check_eq("t6_done_count", done_count, 0);
    check_eq("t6_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rgb_sequencer.md
Name: rgb_sequencer

Overview:
- Sequences the RGB LED through a programmable table of colour steps.
- Each step is held for a number of prescaler ticks.
- The block configures and restarts an external prescaler: it drives that prescaler's limit and synchronous reset and consumes its single-cycle clock_enable as `tick`.
- It sits between the register/host interface and the RGB PWM stage; its red/green/blue outputs are the PWM duty values.

Parameters:
- NUM_ENTRIES, 8: colour table depth; must be ≥2. IDX_W = $clog2(NUM_ENTRIES).
- COLOR_WIDTH, 8: width of each colour channel.
- DURATION_WIDTH, 16: width of the per-step duration in ticks.
- PRESCALER_WIDTH, 8: width of the prescaler limit.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  table write strobe.
- wr_addr  in  IDX_W  table entry to write.
- wr_red / wr_green / wr_blue  in  COLOR_WIDTH each  colour written.
- wr_duration  in  DURATION_WIDTH  hold time in ticks.
- cfg_limit  in  PRESCALER_WIDTH  prescaler divide value, sampled at start.
- cfg_last  in  IDX_W  index of last step, sampled at start.
- cfg_loop  in  1  1 = wrap to entry 0 after last step, sampled at start.
- start  in  1  single-cycle run request.
- stop  in  1  single-cycle abort request.
- tick  in  1  prescaler clock_enable.
- presc_limit  out  PRESCALER_WIDTH  limit to the prescaler.
- presc_reset  out  1  synchronous reset to the prescaler.
- red / green / blue  out  COLOR_WIDTH each  current colour.
- index  out  IDX_W  current step.
- busy  out  1  sequence running.
- done  out  1  one-cycle pulse at end of a non-looping sequence.

Behaviour:
- Reset (synchronous, active-high; clock clock):
  - state IDLE; all table entries = 0.
  - red/green/blue/index/presc_limit/done/busy = 0; presc_reset = 1.
  - Reset mid-run aborts immediately; no done pulse.
- States: IDLE, LOAD, HOLD.
- IDLE:
  - busy = 0, presc_reset = 1, colours = 0.
  - start=1 and stop=0 → LOAD, index ← 0; latch cfg_last, cfg_loop and presc_limit ← cfg_limit.
  - A cfg_limit of 0 is clamped to 1.
- LOAD (exactly 1 cycle):
  - busy = 1, presc_reset = 1.
  - red/green/blue ← table[index].
  - remaining ← table[index].duration, with 0 treated as 1.
  - → HOLD.
- HOLD:
  - busy = 1, presc_reset = 0.
  - On tick with remaining > 1: remaining − 1.
  - On tick with remaining == 1:
    - index ≠ last: index + 1, → LOAD.
    - index == last with loop = 1: index ← 0, → LOAD.
    - index == last with loop = 0: → IDLE, colours ← 0, done = 1 for exactly one cycle (registered, asserted in first IDLE cycle).
  - tick is ignored outside HOLD.
- Timing:
  - The prescaler counter is 0 in the first HOLD cycle.
  - HOLD lasts duration·L cycles (L = latched limit); each step occupies duration·L + 1 cycles including LOAD.
  - Latency from start to first colour visible is 2 cycles.
- stop:
  - In LOAD or HOLD: → IDLE next cycle, colours 0, index 0, no done.
  - stop has priority over tick and start in the same cycle.
- start:
  - start while busy is ignored; cfg_* changes while busy have no effect.
  - start and stop together in IDLE: remain IDLE.
- Table writes:
  - Accepted in any state; last write wins.
  - A LOAD reading the entry written in the same cycle sees the old value.
  - Rewriting the displayed entry does not change outputs until its next LOAD.
- cfg_last: greater than NUM_ENTRIES−1 is legal only for power-of-2 tables. For other depths behaviour is undefined; the bench must not drive it.

Test Plan:
- Entries 0–2 = (FF,00,00,d2), (00,FF,00,d1), (00,00,FF,d3); L=4, last=2, loop=0, start.
  - Required: colours valid 9, 5 and 13 cycles respectively.
  - done pulses once, 1 cycle, with colours 0 and busy 0.
- Same table, last=1, loop=1.
  - Required: index sequence 0,1,0,1… with no done.
  - stop mid-HOLD → IDLE next cycle, presc_reset=1, colours 0, no done.
- Entry 0 duration=0, cfg_limit=0, last=0, loop=0.
  - Required: clamped to duration 1, limit 1; presc_limit=1; step lasts 2 cycles; then done.
- start pulsed during HOLD: ignored, sequence timing unchanged.
  - start+stop in IDLE in the same cycle: stays IDLE, busy=0.
- reset asserted during HOLD of entry 1:
  - Required: next cycle all outputs at reset values, presc_reset=1.
  - A restart then shows colour 0/0/0 (table cleared).
- Rewrite entry 1 while it is in HOLD:
  - Required: displayed colour unchanged until the loop returns to entry 1, then the new value is shown.
  - A write to entry 2 in the same cycle as its LOAD: the old value is displayed.
